// File: rtl/rs_src_trk_multi.sv
`default_nettype none
// ============================================================================
// Module   : rs_src_trk_multi
// Purpose  : Per-entry source-operand tracker for one reservation-station
//            entry. Each of NUM_SRCS sources is either supplied at allocation
//            (GRF/immediate) or waits for a matching ROB writeback on one of
//            NUM_WB snoop ports. It also keeps a saturating pending-age count.
// Ports    : clk, reset_n (async, active-low)
//            e_alloc_*      : allocation request with per-source robid/data
//            e_dealloc_rs1  : release the entry after issue
//            flush          : kill the entry
//            ro_*_rb0       : ROB writeback snoop ports
//            valid_rs1, ready_rs1, all_ready_rs1, from_grf_rs1, src_data,
//            pdg_age_rs1    : registered status / operand outputs
// Revision : 1.0 - initial release
// ============================================================================
module rs_src_trk_multi #(
    parameter int NUM_SRCS = 2,
    parameter int NUM_WB   = 2,
    parameter int DATA_W   = 64,
    parameter int ROBID_W  = 6,
    parameter int AGE_W    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         e_alloc_rs0,
    input  logic [NUM_SRCS-1:0]          e_alloc_from_rob_rs0,
    input  logic [NUM_SRCS*ROBID_W-1:0]  e_alloc_robid_rs0,
    input  logic [NUM_SRCS*DATA_W-1:0]   e_alloc_data_rs0,
    input  logic                         e_dealloc_rs1,
    input  logic                         flush,
    input  logic [NUM_WB-1:0]            ro_valid_rb0,
    input  logic [NUM_WB*ROBID_W-1:0]    ro_robid_rb0,
    input  logic [NUM_WB*DATA_W-1:0]     ro_value_rb0,
    output logic                         valid_rs1,
    output logic [NUM_SRCS-1:0]          ready_rs1,
    output logic                         all_ready_rs1,
    output logic [NUM_SRCS-1:0]          from_grf_rs1,
    output logic [NUM_SRCS*DATA_W-1:0]   src_data,
    output logic [AGE_W-1:0]             pdg_age_rs1
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PDG_ROB = 2'd1,
        ST_READY   = 2'd2
    } src_state_t;

    logic [NUM_SRCS-1:0] w_not_empty;
    logic [NUM_SRCS-1:0] w_pending;
    logic [AGE_W-1:0]    r_age;

    for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
        src_state_t         r_state;
        logic [ROBID_W-1:0] r_robid;
        logic [DATA_W-1:0]  r_data;
        logic               r_from_grf;

        logic [ROBID_W-1:0] w_cmp_id;
        logic               w_hit;
        logic [DATA_W-1:0]  w_hit_val;
        logic               w_conflict;
        logic               w_active;

        // During allocation the snoop compares against the incoming robid so
        // a writeback landing in the same cycle is not lost.
        assign w_cmp_id = e_alloc_rs0 ? e_alloc_robid_rs0[s*ROBID_W +: ROBID_W]
                                      : r_robid;

        // Lowest-indexed matching port wins; a second match carrying a
        // different value is flagged as a conflict.
        always_comb begin
            w_hit      = 1'b0;
            w_hit_val  = '0;
            w_conflict = 1'b0;
            for (int w = 0; w < NUM_WB; w++) begin
                if (ro_valid_rb0[w] && (ro_robid_rb0[w*ROBID_W +: ROBID_W] == w_cmp_id)) begin
                    if (!w_hit) begin
                        w_hit     = 1'b1;
                        w_hit_val = ro_value_rb0[w*DATA_W +: DATA_W];
                    end else if (ro_value_rb0[w*DATA_W +: DATA_W] != w_hit_val) begin
                        w_conflict = 1'b1;
                    end
                end
            end
        end

        // The snoop result is only consumed in these situations.
        assign w_active = !flush &&
                          ((e_alloc_rs0 && e_alloc_from_rob_rs0[s]) ||
                           (!e_alloc_rs0 && !e_dealloc_rs1 && (r_state == ST_PDG_ROB)));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state    <= ST_EMPTY;
                r_robid    <= '0;
                r_data     <= '0;
                r_from_grf <= 1'b0;
            end else if (flush) begin
                r_state <= ST_EMPTY;
            end else if (e_alloc_rs0) begin
                r_robid    <= e_alloc_robid_rs0[s*ROBID_W +: ROBID_W];
                r_from_grf <= ~e_alloc_from_rob_rs0[s];
                if (!e_alloc_from_rob_rs0[s]) begin
                    r_state <= ST_READY;
                    r_data  <= e_alloc_data_rs0[s*DATA_W +: DATA_W];
                end else if (w_hit) begin
                    r_state <= ST_READY;
                    r_data  <= w_hit_val;
                end else begin
                    r_state <= ST_PDG_ROB;
                end
            end else if (e_dealloc_rs1) begin
                r_state <= ST_EMPTY;
            end else if ((r_state == ST_PDG_ROB) && w_hit) begin
                r_state <= ST_READY;
                r_data  <= w_hit_val;
            end
        end

        a_wb_conflict : assert property (@(posedge clk) disable iff (!reset_n)
                                         !(w_active && w_conflict));

        assign w_not_empty[s]                = (r_state != ST_EMPTY);
        assign w_pending[s]                  = (r_state == ST_PDG_ROB);
        assign ready_rs1[s]                  = (r_state == ST_READY);
        assign from_grf_rs1[s]               = r_from_grf;
        assign src_data[s*DATA_W +: DATA_W]  = r_data;
    end

    assign valid_rs1     = |w_not_empty;
    assign all_ready_rs1 = valid_rs1 & (&ready_rs1);
    assign pdg_age_rs1   = r_age;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_age <= '0;
        end else if (flush || e_alloc_rs0 || e_dealloc_rs1) begin
            r_age <= '0;
        end else if (valid_rs1 && (|w_pending) && (r_age != {AGE_W{1'b1}})) begin
            r_age <= r_age + {{(AGE_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_src_trk_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_src_trk_multi
// Purpose  : Self-checking bench for rs_src_trk_multi (default parameters).
//            Expected output snapshots are queued when stimulus is applied
//            and popped when the registered outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_src_trk_multi;

    localparam int SNAP_W = 1 + 2 + 1 + 2 + 128 + 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          alloc = 1'b0;
    logic [1:0]    from_rob = '0;
    logic [11:0]   alloc_robid = '0;
    logic [127:0]  alloc_data = '0;
    logic          dealloc = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    wb_valid = '0;
    logic [11:0]   wb_robid = '0;
    logic [127:0]  wb_value = '0;

    logic          valid_rs1;
    logic [1:0]    ready_rs1;
    logic          all_ready_rs1;
    logic [1:0]    from_grf_rs1;
    logic [127:0]  src_data;
    logic [3:0]    pdg_age_rs1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [SNAP_W-1:0] v;
        string             nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    rs_src_trk_multi dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .e_alloc_rs0          (alloc),
        .e_alloc_from_rob_rs0 (from_rob),
        .e_alloc_robid_rs0    (alloc_robid),
        .e_alloc_data_rs0     (alloc_data),
        .e_dealloc_rs1        (dealloc),
        .flush                (flush),
        .ro_valid_rb0         (wb_valid),
        .ro_robid_rb0         (wb_robid),
        .ro_value_rb0         (wb_value),
        .valid_rs1            (valid_rs1),
        .ready_rs1            (ready_rs1),
        .all_ready_rs1        (all_ready_rs1),
        .from_grf_rs1         (from_grf_rs1),
        .src_data             (src_data),
        .pdg_age_rs1          (pdg_age_rs1)
    );

    always #5 clk = ~clk;

    function automatic logic [SNAP_W-1:0] snap();
        return {valid_rs1, ready_rs1, all_ready_rs1, from_grf_rs1, src_data, pdg_age_rs1};
    endfunction

    // Build an expected snapshot; all_ready follows from valid and ready.
    function automatic logic [SNAP_W-1:0] mk(logic v, logic [1:0] r, logic [1:0] g,
                                             logic [63:0] d1, logic [63:0] d0, logic [3:0] a);
        return {v, r, v & (&r), g, d1, d0, a};
    endfunction

    function automatic exp_t ex(logic [SNAP_W-1:0] v, string nm);
        exp_t t;
        t.v  = v;
        t.nm = nm;
        return t;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc = 1'b0; dealloc = 1'b0; flush = 1'b0; wb_valid = '0;
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        sb.push_back(ex(mk(0, 2'b00, 2'b00, 64'h0, 64'h0, 4'd0), "reset_state"));
        cyc(); cyc();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        reset_n = 1'b1;
        // src0 waits on robid 5, src1 supplied from GRF
        alloc = 1'b1; from_rob = 2'b01; alloc_robid = {6'd0, 6'd5}; alloc_data = {64'h11, 64'h0};
        sb.push_back(ex(mk(1, 2'b10, 2'b10, 64'h11, 64'h0, 4'd0), "rst_alloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        cyc();
        // asynchronous reset: outputs clear without a clock edge
        reset_n = 1'b0;
        sb.push_back(ex(mk(0, 2'b00, 2'b00, 64'h0, 64'h0, 4'd0), "rst_async"));
        #1;
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        cyc();
        reset_n = 1'b1;
        wb_valid = 2'b01; wb_robid = {6'd0, 6'd5}; wb_value = {64'h0, 64'h99};
        sb.push_back(ex(mk(0, 2'b00, 2'b00, 64'h0, 64'h0, 4'd0), "rst_wb_ignored"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
    endtask

    task automatic test_mixed();
        alloc = 1'b1; from_rob = 2'b10; alloc_robid = {6'h23, 6'h00}; alloc_data = {64'h0, 64'hAA};
        sb.push_back(ex(mk(1, 2'b01, 2'b01, 64'h0, 64'hAA, 4'd0), "mixed_alloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        wb_valid = 2'b10; wb_robid = {6'h23, 6'h00}; wb_value = {64'h1234, 64'h0};
        sb.push_back(ex(mk(1, 2'b11, 2'b01, 64'h1234, 64'hAA, 4'd1), "mixed_wb"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        sb.push_back(ex(mk(1, 2'b11, 2'b01, 64'h1234, 64'hAA, 4'd1), "mixed_age_hold"));
        cyc();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        dealloc = 1'b1;
        sb.push_back(ex(mk(0, 2'b00, 2'b01, 64'h1234, 64'hAA, 4'd0), "mixed_dealloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
    endtask

    task automatic test_bypass();
        alloc = 1'b1; from_rob = 2'b11; alloc_robid = {6'd9, 6'd7};
        wb_valid = 2'b01; wb_robid = {6'd0, 6'd7}; wb_value = {64'h0, 64'h55};
        sb.push_back(ex(mk(1, 2'b01, 2'b00, 64'h1234, 64'h55, 4'd0), "bypass_alloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        wb_valid = 2'b01; wb_robid = {6'd0, 6'd7}; wb_value = {64'h0, 64'h66};
        sb.push_back(ex(mk(1, 2'b01, 2'b00, 64'h1234, 64'h55, 4'd1), "bypass_late_wb"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        // both ports match src1 with the same value
        wb_valid = 2'b11; wb_robid = {6'd9, 6'd9}; wb_value = {64'h77, 64'h77};
        sb.push_back(ex(mk(1, 2'b11, 2'b00, 64'h77, 64'h55, 4'd2), "bypass_dual_wb"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
    endtask

    task automatic test_wrap();
        alloc = 1'b1; from_rob = 2'b01; alloc_robid = {6'd0, 6'b100011}; alloc_data = {64'hBB, 64'h0};
        sb.push_back(ex(mk(1, 2'b10, 2'b10, 64'hBB, 64'h55, 4'd0), "wrap_alloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        wb_valid = 2'b01; wb_robid = {6'd0, 6'b000011}; wb_value = {64'h0, 64'hDEAD};
        sb.push_back(ex(mk(1, 2'b10, 2'b10, 64'hBB, 64'h55, 4'd1), "wrap_mismatch"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        wb_valid = 2'b10; wb_robid = {6'b100011, 6'd0}; wb_value = {64'hBEEF, 64'h0};
        sb.push_back(ex(mk(1, 2'b11, 2'b10, 64'hBB, 64'hBEEF, 4'd2), "wrap_match"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
    endtask

    task automatic test_flush();
        flush = 1'b1; alloc = 1'b1; from_rob = 2'b00; alloc_data = {64'hAB, 64'hCD};
        sb.push_back(ex(mk(0, 2'b00, 2'b10, 64'hBB, 64'hBEEF, 4'd0), "flush_vs_alloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        alloc = 1'b1; from_rob = 2'b11; alloc_robid = {6'h12, 6'h11};
        sb.push_back(ex(mk(1, 2'b00, 2'b00, 64'hBB, 64'hBEEF, 4'd0), "flush_pend_alloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        flush = 1'b1;
        sb.push_back(ex(mk(0, 2'b00, 2'b00, 64'hBB, 64'hBEEF, 4'd0), "flush_pending"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        wb_valid = 2'b11; wb_robid = {6'h12, 6'h11}; wb_value = {64'hDD, 64'hCC};
        sb.push_back(ex(mk(0, 2'b00, 2'b00, 64'hBB, 64'hBEEF, 4'd0), "flush_stale_wb"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
    endtask

    task automatic test_age_saturation();
        alloc = 1'b1; from_rob = 2'b01; alloc_robid = {6'd0, 6'h2A}; alloc_data = {64'h5, 64'h0};
        sb.push_back(ex(mk(1, 2'b10, 2'b10, 64'h5, 64'hBEEF, 4'd0), "age_alloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        for (int i = 1; i <= 20; i++) begin
            sb.push_back(ex(mk(1, 2'b10, 2'b10, 64'h5, 64'hBEEF, (i > 15) ? 4'd15 : 4'(i)),
                            $sformatf("age_count_%0d", i)));
            cyc();
            e = sb.pop_front(); n_cmp++;
            if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        end
        wb_valid = 2'b01; wb_robid = {6'd0, 6'h2A}; wb_value = {64'h0, 64'hF00D};
        sb.push_back(ex(mk(1, 2'b11, 2'b10, 64'h5, 64'hF00D, 4'd15), "age_after_wb"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        sb.push_back(ex(mk(1, 2'b11, 2'b10, 64'h5, 64'hF00D, 4'd15), "age_hold_ready"));
        cyc();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
        dealloc = 1'b1;
        sb.push_back(ex(mk(0, 2'b00, 2'b10, 64'h5, 64'hF00D, 4'd0), "age_dealloc"));
        cyc(); idle();
        e = sb.pop_front(); n_cmp++;
        if (snap() !== e.v) begin n_fail++; $display("FAIL %s got=%h want=%h", e.nm, snap(), e.v); end
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_bypass();
        test_wrap();
        test_flush();
        test_age_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
